// File: rtl/buffer_pkg.sv
// Shared defaults and elaboration-time helpers for the stall buffer FIFO.
// Provides the payload width default, pointer/count width helpers,
// the almost-full default, and legality predicates for parameters.
package buffer_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // Pointer width: log2 of a power-of-two depth, never below 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Two slots of slack by default so the stall manager has time to react.
  function automatic int afull_default(input int depth);
    return depth - 2;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_legal(input int depth, input int level);
    return (level >= 1) && (level <= depth);
  endfunction

endpackage

// File: rtl/buffer_ram.sv
// Storage array for the stall buffer: DEPTH x DATA_W, no reset on contents.
// Ports: clk; i_we/i_waddr/i_wdata synchronous write; i_raddr -> o_rdata
// asynchronous (combinational) read.
module buffer_ram
  import buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 8,
  localparam int AW    = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stall_buffer_fifo.sv
// Elastic buffer between pipeline stages under global stall control; 1-cycle
// latency through a registered output stage that holds while stall is high.
// Ports: clk/reset (sync, active-high); in_data/in_valid upstream; stall,
// flush control; out_data/out_valid registered; to_stall_mgmt, full, count,
// overflow (sticky) status, all derived from registered state only.
module stall_buffer_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = afull_default(DEPTH),
  localparam int AW         = ptr_width(DEPTH),
  localparam int CW         = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              to_stall_mgmt,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("stall_buffer_fifo: DEPTH must be a power of two and >= 2");
  end
  if (!afull_legal(DEPTH, AFULL_LEVEL)) begin : g_bad_afull
    $error("stall_buffer_fifo: AFULL_LEVEL must lie in 1..DEPTH");
  end

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Stalled: write only if there is room. Draining: write alongside the pop,
  // which is legal even when full because a slot frees the same edge.
  // Empty and not stalled: the beat bypasses storage entirely.
  assign w_we = !reset && !flush && in_valid &&
                (stall ? !w_full : !w_empty);

  buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (stall) begin
      if (in_valid) begin
        if (!w_full) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_count  <= r_count + CW'(1);
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end else if (!w_empty) begin
      r_out_data  <= w_rdata;
      r_out_valid <= 1'b1;
      r_rd_ptr    <= r_rd_ptr + AW'(1);
      if (in_valid) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end else begin
        r_count <= r_count - CW'(1);
      end
    end else begin
      r_out_data  <= in_data;
      r_out_valid <= in_valid;
    end
  end

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign count         = r_count;
  assign full          = w_full;
  assign to_stall_mgmt = (r_count >= AFULL_C);
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_stall_buffer_fifo.sv
module tb_stall_buffer_fifo;

  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int SW  = 1 + DW + 4 + 1 + 1 + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          to_stall_mgmt;
  logic          full;
  logic [3:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stall_buffer_fifo #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .to_stall_mgmt (to_stall_mgmt),
    .full          (full),
    .count         (count),
    .overflow      (overflow)
  );

  // Reference model: a queue of pending beats plus the visible output stage.
  logic [DW-1:0] mq[$];
  logic          m_ov;
  logic [DW-1:0] m_od;
  logic          m_ovf;

  task automatic model_edge(input logic r, input logic fl, input logic st,
                            input logic iv, input logic [DW-1:0] d);
    if (r || fl) begin
      mq.delete();
      m_ov = 1'b0; m_od = '0; m_ovf = 1'b0;
    end else if (st) begin
      if (iv) begin
        if (mq.size() < DEP) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end else if (mq.size() > 0) begin
      m_od = mq.pop_front();
      m_ov = 1'b1;
      if (iv) mq.push_back(d);
    end else begin
      m_od = d;
      m_ov = iv;
    end
  endtask

  function automatic logic [SW-1:0] m_snap();
    return {m_ov, m_od, 4'(mq.size()), (mq.size() == DEP),
            (mq.size() >= AF), m_ovf};
  endfunction

  function automatic logic [SW-1:0] d_snap();
    return {out_valid, out_data, count, full, to_stall_mgmt, overflow};
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic r, input logic fl, input logic st,
                      input logic iv, input logic [DW-1:0] d);
    reset = r; flush = fl; stall = st; in_valid = iv; in_data = d;
    @(posedge clk);
    model_edge(r, fl, st, iv, d);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 1, 32'hDEAD);
    checks++;
    if (d_snap() !== {SW{1'b0}}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", d_snap(), {SW{1'b0}});
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] v [3];
    v[0] = 32'hA1; v[1] = 32'hA2; v[2] = 32'hA3;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, v[i]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== v[i] || count !== 4'd0) begin
        errors++;
        $display("FAIL bypass[%0d]: got v=%b d=%h c=%0d expected v=1 d=%h c=0",
                 i, out_valid, out_data, count, v[i]);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEP; i++) begin
      step(0, 0, 1, 1, 32'h10 + DW'(i));
      checks++;
      if (count !== 4'(i + 1) || to_stall_mgmt !== (i + 1 >= AF) ||
          full !== (i == DEP - 1) || out_valid !== 1'b1 ||
          out_data !== 32'hA3) begin
        errors++;
        $display("FAIL fill[%0d]: got c=%0d af=%b f=%b v=%b d=%h expected c=%0d af=%b f=%b v=1 d=a3",
                 i, count, to_stall_mgmt, full, out_valid, out_data,
                 i + 1, (i + 1 >= AF), (i == DEP - 1));
      end
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 1, 1, 32'h18);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got c=%0d ovf=%b f=%b expected c=8 ovf=1 f=1",
               count, overflow, full);
    end
    step(0, 0, 1, 0, '0);
    checks++;
    if (overflow !== 1'b1 || out_data !== 32'hA3) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b d=%h expected ovf=1 d=a3",
               overflow, out_data);
    end
  endtask

  task automatic test_drain_push();
    logic [DW-1:0] exp_d [10];
    for (int i = 0; i < 8; i++) exp_d[i] = 32'h10 + DW'(i);
    exp_d[8] = 32'h20; exp_d[9] = 32'h21;
    for (int k = 0; k < 10; k++) begin
      int ec;
      if (k == 0)      step(0, 0, 0, 1, 32'h20);
      else if (k == 1) step(0, 0, 0, 1, 32'h21);
      else             step(0, 0, 0, 0, 32'hFF);
      ec = (k < 2) ? 8 : 9 - k;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || count !== 4'(ec) ||
          overflow !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d]: got v=%b d=%h c=%0d ovf=%b expected v=1 d=%h c=%0d ovf=1",
                 k, out_valid, out_data, count, overflow, exp_d[k], ec);
      end
    end
    step(0, 0, 0, 0, '0);
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty: got v=%b c=%0d expected v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_flush();
    step(0, 0, 0, 1, 32'h40);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 1, 32'h40 + DW'(i));
    checks++;
    if (count !== 4'd5 || out_valid !== 1'b1 || out_data !== 32'h40) begin
      errors++;
      $display("FAIL flush_setup: got c=%0d v=%b d=%h expected c=5 v=1 d=40",
               count, out_valid, out_data);
    end
    step(0, 1, 1, 1, 32'h99);
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 ||
        full !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear: got c=%0d v=%b ovf=%b f=%b d=%h expected all 0",
               count, out_valid, overflow, full, out_data);
    end
    step(0, 0, 0, 1, 32'h30);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h30 || count !== 4'd0) begin
      errors++;
      $display("FAIL flush_bypass: got v=%b d=%h c=%0d expected v=1 d=30 c=0",
               out_valid, out_data, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h50 + DW'(i));
    step(0, 0, 0, 0, '0);
    checks++;
    if (count !== 4'd3 || out_data !== 32'h50) begin
      errors++;
      $display("FAIL rst_mid_setup: got c=%0d d=%h expected c=3 d=50", count, out_data);
    end
    step(1, 0, 0, 1, 32'h77);
    checks++;
    if (d_snap() !== {SW{1'b0}}) begin
      errors++;
      $display("FAIL rst_mid_clear: got %h expected %h", d_snap(), {SW{1'b0}});
    end
    step(0, 0, 0, 0, '0);
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_stale: got v=%b c=%0d expected v=0 c=0", out_valid, count);
    end
    step(0, 0, 0, 1, 32'h88);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h88) begin
      errors++;
      $display("FAIL rst_mid_bypass: got v=%b d=%h expected v=1 d=88", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 2000; n++) begin
      logic r, fl, st, iv;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 65 : 35));
      iv = ($urandom_range(0, 3) != 0);
      step(r, fl, st, iv, $urandom());
      checks++;
      if (d_snap() !== m_snap()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: got %h expected %h", n, d_snap(), m_snap());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill();
    test_overflow();
    test_drain_push();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
